// File: rtl/seg7_pkg.sv
// Purpose: shared types and segment code constants for the multiplexed 7-segment driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: digit_t (4-bit digit value), seg_t ({a..g}, a = MSB),
//           SEG_0..SEG_F, SEG_DASH, SEG_BLANK (active-high logical codes).
package seg7_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1110011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_DASH  = 7'b0000001;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Purpose: datapath <-> display driver bundle (control, digit data, display pins).
// Latency: n/a (wires only).
// Backpressure: none; the driver accepts a load strobe on any cycle.
// master: datapath side (drives en/load/digits_in/dp_in/hex_mode/lzb_en, sees pins).
// slave : driver side (drives seg_o/dp_o/an_o/scan_idx_o).
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    hex_mode;
  logic                    lzb_en;
  logic [6:0]              seg_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [IDX_W-1:0]        scan_idx_o;

  modport master (
    output en, load, digits_in, dp_in, hex_mode, lzb_en,
    input  seg_o, dp_o, an_o, scan_idx_o
  );

  modport slave (
    input  en, load, digits_in, dp_in, hex_mode, lzb_en,
    output seg_o, dp_o, an_o, scan_idx_o
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Purpose: digit value -> active-high 7-segment code (BCD, optional hex letters, dash, blank).
// Latency: combinational.
// Backpressure: none.
// Ports: value_i digit, hex_mode_i (1 = A..F, 0 = dash for 10..15), blank_i forces all-off,
//        seg_o {a..g}.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  digit_t value_i,
  input  logic   hex_mode_i,
  input  logic   blank_i,
  output seg_t   seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if ((value_i > 4'd9) && !hex_mode_i) begin
      seg_o = SEG_DASH;
    end else begin
      case (value_i)
        4'h0:    seg_o = SEG_0;
        4'h1:    seg_o = SEG_1;
        4'h2:    seg_o = SEG_2;
        4'h3:    seg_o = SEG_3;
        4'h4:    seg_o = SEG_4;
        4'h5:    seg_o = SEG_5;
        4'h6:    seg_o = SEG_6;
        4'h7:    seg_o = SEG_7;
        4'h8:    seg_o = SEG_8;
        4'h9:    seg_o = SEG_9;
        4'hA:    seg_o = SEG_A;
        4'hB:    seg_o = SEG_B;
        4'hC:    seg_o = SEG_C;
        4'hD:    seg_o = SEG_D;
        4'hE:    seg_o = SEG_E;
        default: seg_o = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: N-digit multiplexed 7-segment scan driver with shadow register and anti-ghost slot.
// Latency: pins registered; a shadow change on the shown digit reaches seg_o one edge after load.
// Backpressure: none; load is accepted every cycle (even with en low).
// Ports: clk, rst_n (async active-low); bus (slave modport): en, load, digits_in, dp_in,
//        hex_mode, lzb_en in; seg_o, dp_o, an_o (pin polarity per parameters), scan_idx_o out.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = $clog2(SCAN_DIV);

  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  // Inactive pin levels; XOR with these converts logical values to pin polarity.
  localparam seg_t                  SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

  digit_t [NUM_DIGITS-1:0] shadow_q;
  logic   [NUM_DIGITS-1:0] dp_shadow_q;
  logic   [PW-1:0]         presc_q, presc_d;
  logic   [IDX_W-1:0]      idx_q, idx_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic   [NUM_DIGITS-1:0] an_q, an_d;

  logic                    wrap;
  logic   [NUM_DIGITS-1:0] lz_blank;
  seg_t                    cur_seg;

  assign wrap = bus.en && (presc_q == PRESC_LAST);

  // lz_blank[i]: nibbles i..top are all zero. Digit 0 is never blanked.
  always_comb begin : lead_zero
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (shadow_q[i] == 4'd0);
      lz_blank[i] = zero_above;
    end
  end

  seg7_hex_decoder u_dec (
    .value_i    (shadow_q[idx_q]),
    .hex_mode_i (bus.hex_mode),
    .blank_i    (bus.lzb_en && lz_blank[idx_q]),
    .seg_o      (cur_seg)
  );

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (bus.en) begin
      if (wrap) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // The wrap edge loads all-inactive pins: this is the anti-ghost blank slot
  // while an_o moves to the next digit.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (bus.en && !wrap) begin
      seg_d = cur_seg ^ SEG_OFF;
      dp_d  = dp_shadow_q[idx_q] ^ DP_OFF;
      an_d  = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      an_q        <= AN_OFF;
    end else begin
      if (bus.load) begin
        shadow_q    <= bus.digits_in;
        dp_shadow_q <= bus.dp_in;
      end
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg_o      = seg_q;
  assign bus.dp_o       = dp_q;
  assign bus.an_o       = an_q;
  assign bus.scan_idx_o = idx_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor to the team's single-digit BCD-to-7-segment decoder.
- Drives an N-digit common-anode/cathode multiplexed display from one segment bus plus per-digit select lines.
- Adds a hex mode, out-of-range dash, leading-zero blanking, decimal points, a latched shadow register, refresh prescaler and anti-ghost blank slot.
- Sits between the datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, digit count (1..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 0, 1 = invert seg_o/dp_o pins.
- AN_ACTIVE_LOW, 1, 1 = an_o active-low.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  display enable; low = all outputs inactive, scan frozen.
- load  in  1  strobe: latch digits_in/dp_in into shadow.
- digits_in  in  4*NUM_DIGITS  nibble i = digit i (digit 0 = rightmost/LSD).
- dp_in  in  NUM_DIGITS  decimal point per digit.
- hex_mode  in  1  1 = show 10..15 as A,b,C,d,E,F; 0 = show them as dash.
- lzb_en  in  1  leading-zero blanking enable.
- seg_o  out  7  {a,b,c,d,e,f,g}, a = MSB, registered.
- dp_o  out  1  decimal point, registered.
- an_o  out  NUM_DIGITS  one-hot digit select, registered.
- scan_idx_o  out  clog2(NUM_DIGITS) (min 1)  currently driven digit index.

Behaviour:
- Reset (async, rst_n=0):
  - shadow=0, dp shadow=0, prescaler=0, idx=0.
  - seg_o/dp_o/an_o at inactive pin level.
  - scan_idx_o=0.
- Segment codes, active-high logical form:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - dash=0000001, blank=0000000.
  - SEG_ACTIVE_LOW inverts seg_o and dp_o at the pin.
- Shadow:
  - load sampled high at edge E: shadow <= digits_in, dp shadow <= dp_in at E.
  - Inputs are ignored otherwise.
  - load is honoured even when en=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps when en=1; holds when en=0.
  - Wrap edge: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, and the blank slot is set.
- Blank slot:
  - The first cycle after each wrap edge drives an_o and seg_o/dp_o inactive (anti-ghost).
  - The remaining SCAN_DIV-1 cycles drive an_o one-hot at idx, with seg_o/dp_o decoded from shadow[idx].
- Output latency:
  - Outputs are registered from current idx/shadow.
  - A shadow change on the displayed digit appears on seg_o 1 edge after E, unless in the blank slot.
- Leading-zero blanking (lzb_en=1):
  - Digit i>0 is blank if nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked; all-zero value shows a single "0".
  - The dp of a blanked digit is still driven from dp shadow.
- en deasserted: at the next edge all outputs go inactive; prescaler and idx hold.
- en reasserted: scanning resumes from the held prescaler/idx.
- NUM_DIGITS=1: idx is constant 0, but blank slot still occurs each wrap.
- Simultaneous load and wrap on the same edge: the new idx uses the new shadow value on the first non-blank cycle.
- Reset mid-scan: immediate return to reset values; no partial digit is driven.

Decomposition:
- Package seg7_pkg holds:
  - Segment code constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK.
  - Digit-value typedef (4-bit).
- Sub-module seg7_hex_decoder: combinational {value, hex_mode, blank} -> 7-bit active-high code.
- One instance, muxed by idx; it generalises the existing BCD decoder.

Test Plan:
- Reset/enable: rst_n low, then release with en=1, NUM_DIGITS=4, SCAN_DIV=4 -> outputs inactive during reset; an_o sequence 0001,0010,0100,1000,0001 with one all-off cycle after each wrap.
- Decimal digits: load digits_in=16'h1234, hex_mode=0 -> slots show seg 0110011(4), 1111001(3), 1101101(2), 0110000(1).
- Hex and dash: digits_in=16'hAF0C:
  - hex_mode=1 -> C=1001110, 0=1111110, F=1000111, A=1110111.
  - hex_mode=0 -> A/F/C positions show 0000001.
- Leading zeros: digits_in=16'h0050, lzb_en=1 -> digits 3,2 blank, digit 1=1011011, digit 0=1111110; digits_in=0 -> only digit 0 shows 1111110.
- Load timing and dp: pulse load mid-slot on the displayed digit with dp_in=4'b0001 -> seg_o/dp_o change exactly 1 edge later; load held low -> later digits_in changes have no effect.
- en/async reset: drop en mid-slot -> next edge all inactive, scan_idx_o frozen; assert rst_n low between edges -> outputs inactive immediately, scan_idx_o=0.
